// File: rtl/aibcr3_dcc_dlyline_ctrl_if.sv
// Control bus between the DCC code generator and the delay-line sequencer.
// The master side issues target codes and freeze; the slave side (the
// sequencer) returns the applied code, thermometer select and status.
interface aibcr3_dcc_dlyline_ctrl_if #(
  parameter int unsigned NCELL = 16,
  parameter int unsigned CW    = 5
);

  logic             code_vld;
  logic [CW-1:0]    dly_code;
  logic             freeze;
  logic [NCELL-1:0] bk;
  logic [CW-1:0]    cur_code;
  logic             busy;
  logic             code_ack;
  logic             clamp;
  logic             drop;

  modport master (
    output code_vld, dly_code, freeze,
    input  bk, cur_code, busy, code_ack, clamp, drop
  );

  modport slave (
    input  code_vld, dly_code, freeze,
    output bk, cur_code, busy, code_ack, clamp, drop
  );

endinterface

// File: rtl/aibcr3_dcc_dlyline_ctrl.sv
// DCC delay-line sequencer: walks the thermometer-coded delay line one cell
// at a time toward a requested code, with a settle interval after each step
// so the line output never sees a multi-cell jump.
module aibcr3_dcc_dlyline_ctrl #(
  parameter int unsigned NCELL    = 16,
  parameter int unsigned CW       = 5,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned RST_CODE = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  aibcr3_dcc_dlyline_ctrl_if.slave bus
);

  localparam int unsigned     CNTW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   NCELL_C  = CW'(NCELL);
  localparam logic [CW-1:0]   RST_C    = CW'(RST_CODE);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE - 1);

  // Thermometer encode: bit i set iff i < c.
  function automatic logic [NCELL-1:0] therm(input logic [CW-1:0] c);
    logic [NCELL-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      t[i] = (CW'(i) < c);
    end
    return t;
  endfunction

  localparam logic [NCELL-1:0] RST_BK = therm(RST_C);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    target_q, target_d;
  logic [CW-1:0]    cur_q, cur_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NCELL-1:0] bk_q, bk_d;
  logic             clamp_q, clamp_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             drop_q, drop_d;

  // Next-state and next-output logic for the step/settle sequencer.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    clamp_d  = clamp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.code_vld) begin
          if (bus.dly_code > NCELL_C) begin
            target_d = NCELL_C;
            clamp_d  = 1'b1;
          end else begin
            target_d = bus.dly_code;
          end
          state_d = (target_d == cur_q) ? S_DONE : S_STEP;
        end
      end

      S_STEP: begin
        if (cur_q < target_q) begin
          cur_d = cur_q + CW'(1);
        end else if (cur_q > target_q) begin
          cur_d = cur_q - CW'(1);
        end
        cnt_d   = CNT_LOAD;
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (!bus.freeze) begin
          if (cnt_q == '0) begin
            state_d = (cur_q == target_q) ? S_DONE : S_STEP;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // bk is re-encoded from the next code, so a single-code step can only
    // flip one bit and the register is a thermometer by construction.
    bk_d   = therm(cur_d);
    // busy also covers the IDLE cycle right after DONE.
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    ack_d  = (state_d == S_DONE);
    drop_d = bus.code_vld && (state_q != S_IDLE);
  end

  // State and output registers, asynchronously reset to the reset code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= RST_C;
      cur_q    <= RST_C;
      cnt_q    <= '0;
      bk_q     <= RST_BK;
      clamp_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      bk_q     <= bk_d;
      clamp_q  <= clamp_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.bk       = bk_q;
  assign bus.cur_code = cur_q;
  assign bus.busy     = busy_q;
  assign bus.code_ack = ack_q;
  assign bus.clamp    = clamp_q;
  assign bus.drop     = drop_q;

endmodule

// File: doc/aibcr3_dcc_dlyline_ctrl.md
# aibcr3_dcc_dlyline_ctrl

Sequencer for a thermometer-controlled DCC delay line built from a chain of `NCELL` replica delay cells. It accepts a binary target delay code over a valid/ack handshake and converts it into the per-cell `bk` select vector. It moves the line one cell per step, with a programmable settle interval between steps, so the delay-line output never sees a multi-cell jump. The block sits in the DCC/DLL control path between the code-generation logic and the delay-line instance.

## Interface
- `NCELL`, 16: number of delay cells driven (`bk` width).
- `CW`, 5: code width; must satisfy 2^CW > NCELL.
- `SETTLE`, 4: settle cycles after each single-cell step (≥1).
- `RST_CODE`, 0: line code loaded at reset (≤ NCELL).

- `clk`  input  1  block clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `code_vld`  input  1  target code valid; sampled only in IDLE.
- `dly_code`  input  CW  requested number of enabled cells.
- `freeze`  input  1  stall stepping while high; current code is held.
- `bk`  output  NCELL  thermometer select: `bk[i]=1` iff `i < cur_code`; registered.
- `cur_code`  output  CW  code currently applied to the line.
- `busy`  output  1  high in STEP, SETTLE and DONE.
- `code_ack`  output  1  one-cycle pulse when the target has been reached.
- `clamp`  output  1  sticky; set when a sampled `dly_code` > NCELL.
- `drop`  output  1  one-cycle pulse when `code_vld` is asserted while not in IDLE.

## Operation
- States: IDLE, STEP, SETTLE, DONE. State, `cur_code`, `bk`, settle counter and target register are all flops.
- IDLE + `code_vld`: latch `target = min(dly_code, NCELL)`. If `dly_code` > NCELL, set `clamp`. If `target == cur_code`, go to DONE; otherwise go to STEP.
- STEP (one cycle): `cur_code` moves ±1 toward `target`. `bk` is updated in the same edge and changes by exactly one bit: bit `cur_code` sets on increment, bit `cur_code-1` clears on decrement. Load counter with `SETTLE-1` and go to SETTLE.
- SETTLE: counter decrements each cycle while `freeze=0`. It holds while `freeze=1`. At count 0 with `freeze=0`: go to DONE if `cur_code == target`, else go to STEP.
- DONE (one cycle): `code_ack=1`, then return to IDLE.
- `freeze` has no effect in IDLE, STEP or DONE. A STEP already entered always completes.
- `code_vld` in STEP, SETTLE or DONE is ignored: the target is unchanged and `drop` pulses the next cycle.
- `clamp` clears only on reset.
- Invariant: `bk` is always a valid thermometer code with popcount equal to `cur_code`. `cur_code` never exceeds NCELL and never wraps below 0.

## Timing
- Reset values: state IDLE; `cur_code = RST_CODE`; `bk` is thermometer of `RST_CODE`; `busy=0`; `code_ack=0`; `clamp=0`; `drop=0`.
- Reset asserted mid-sequence returns all outputs to reset values immediately. No ack is issued for the aborted request.
- Latency is measured from the edge that samples `code_vld` (edge 0):
  - Zero-step request: DONE after edge 0; `code_ack` is high in cycle 1.
  - N-step request: each step costs 1 + SETTLE edges. DONE is reached at edge N·(1+SETTLE); `code_ack` is high in the following cycle.
- A `freeze` held for F cycles in SETTLE adds exactly F cycles.
- `bk` changes at most once per 1+SETTLE cycles.
- `busy` rises the cycle after edge 0 and falls the cycle after `code_ack`.
- A new request is accepted at the earliest in the cycle after `code_ack`.

## Test plan
- Reset with RST_CODE=0, then `dly_code=3`, SETTLE=4 → `bk` goes 0x0001, 0x0003, 0x0007 at edges 1, 6, 11. `code_ack` is high for exactly one cycle after edge 15; `busy` falls the next cycle.
- From `cur_code=3`, request 0 → `bk` goes 0x0003, 0x0001, 0x0000 with single-bit changes. `code_ack` is high after edge 15.
- Request equal to `cur_code` (3) → `bk` is unchanged; `code_ack` is high in cycle 1; `busy` is high for exactly 2 cycles.
- `dly_code=20` with NCELL=16 → `clamp` is set and remains set. The line ramps to 16 (`bk=0xFFFF`) and stops; no wrap occurs.
- During a ramp, assert `freeze` for 7 cycles inside SETTLE, and pulse `code_vld` with a new code during STEP → ack is delayed by exactly 7 cycles, `drop` pulses once, and the original target is reached.
- Deassert `rst_n` mid-ramp at `cur_code=2` → all outputs are immediately at reset values, with no `code_ack`. A fresh request then ramps from RST_CODE.
